// File: rtl/spatz_pkg.sv
// Shared types for the Spatz issue path: execution-unit selector and request word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spatz_pkg;

  // Number of functional units behind the issue controller (VFU, VLSU, VSLDU).
  localparam int NrUnits = 3;

  // CON targets the vector CSR block; unit index = ex_unit value minus 1.
  typedef enum logic [1:0] {
    CON = 2'd0,
    VFU = 2'd1,
    LSU = 2'd2,
    SLD = 2'd3
  } ex_unit_e;

  typedef struct packed {
    logic [7:0] op;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic       reset_vstart;
    ex_unit_e   ex_unit;
  } spatz_req_t;

  localparam int ReqWidth = $bits(spatz_req_t);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } issue_state_e;

endpackage

// File: rtl/spatz_issue_cnt.sv
// In-flight op counter for one unit: up on issue, down on retire, saturating.
// Latency: count updates at the clock edge after inc/dec; flags are registered-state only.
// Backpressure: full_o blocks further issue upstream; a retire at zero is ignored.
module spatz_issue_cnt #(
  parameter int MaxOutstanding = 4,
  localparam int CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                dec_eff;

  assign full_o  = (cnt_q == MaxCnt);
  assign empty_o = (cnt_q == '0);
  // A retire pulse with nothing in flight must not wrap the counter.
  assign dec_eff = dec_i & ~empty_o;
  assign cnt_o   = cnt_q;

  // Next count: simultaneous issue and retire cancel; never step past the limits.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_eff && !full_o) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (dec_eff && !inc_i) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Flag a retire pulse from a unit that has nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(dec_i && empty_o))
        else $warning("spatz_issue_cnt: retire pulse with no op in flight ignored");
    end
  end
`endif

endmodule

// File: rtl/spatz_issue_ctrl.sv
// In-order issue of decoded ops to the CSR block or one functional unit; config ops wait for all units to drain.
// Latency: zero-cycle issue (request to valid/ready is combinational); config ops wait in DRAIN until counters reach 0.
// Backpressure: req_ready_o follows the target unit ready and its in-flight limit; DRAIN stalls every younger op.
module spatz_issue_ctrl #(
  parameter int NrUnits        = spatz_pkg::NrUnits,
  parameter int MaxOutstanding = 4,
  localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [spatz_pkg::ReqWidth-1:0] req_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          vill_i,
  output logic [spatz_pkg::ReqWidth-1:0] vcsr_req_o,
  output logic                          vcsr_valid_o,
  output logic [spatz_pkg::ReqWidth-1:0] unit_req_o,
  output logic [NrUnits-1:0]            unit_valid_o,
  input  logic [NrUnits-1:0]            unit_ready_i,
  input  logic [NrUnits-1:0]            unit_done_i,
  output logic                          illegal_o,
  output logic                          busy_o
);

  import spatz_pkg::*;

  spatz_req_t   req;
  spatz_req_t   unit_req;
  issue_state_e state_q, state_d;

  logic [NrUnits-1:0][CntWidth-1:0] cnt;
  logic [NrUnits-1:0]               full;
  logic [NrUnits-1:0]               empty;
  logic [NrUnits-1:0]               unit_sel;
  logic [NrUnits-1:0]               unit_drained;
  logic                             all_empty;
  logic                             all_drained;
  logic                             is_con;

  assign req        = spatz_req_t'(req_i);
  assign is_con     = (req.ex_unit == CON);
  assign vcsr_req_o = req_i;

  // Units always start from vstart=0 once the op reaches them.
  always_comb begin
    unit_req              = req;
    unit_req.reset_vstart = 1'b1;
  end
  assign unit_req_o = unit_req;

  // Decode the target unit into a one-hot select (zero for CON).
  always_comb begin
    unit_sel = '0;
    for (int i = 0; i < NrUnits; i++) begin
      unit_sel[i] = (int'(req.ex_unit) == i + 1);
    end
  end

  // One in-flight counter per unit; a handshake is the only increment source.
  for (genvar i = 0; i < NrUnits; i++) begin : g_unit
    spatz_issue_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (unit_valid_o[i] & unit_ready_i[i]),
      .dec_i  (unit_done_i[i]),
      .cnt_o  (cnt[i]),
      .full_o (full[i]),
      .empty_o(empty[i])
    );
  end

  // Drained means every counter reaches 0 at this edge. No unit issues while
  // draining, so only retire pulses can lower a counter here.
  always_comb begin
    unit_drained = '0;
    for (int i = 0; i < NrUnits; i++) begin
      unit_drained[i] = empty[i] | ((cnt[i] == CntWidth'(1)) & unit_done_i[i]);
    end
  end

  assign all_empty   = &empty;
  assign all_drained = &unit_drained;
  assign busy_o      = (state_q != IDLE) | ~all_empty;

  // Next-state and issue routing; all outputs idle during reset or without a request.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    vcsr_valid_o = 1'b0;
    unit_valid_o = '0;
    illegal_o    = 1'b0;
    if (!rst_i && req_valid_i) begin
      case (state_q)
        IDLE: begin
          if (is_con) begin
            if (all_empty) begin
              req_ready_o  = 1'b1;
              vcsr_valid_o = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else if (vill_i) begin
            req_ready_o = 1'b1;
            illegal_o   = 1'b1;
          end else begin
            unit_valid_o = unit_sel & ~full;
            req_ready_o  = |(unit_sel & unit_ready_i & ~full);
          end
        end
        DRAIN: begin
          if (all_drained) begin
            req_ready_o  = 1'b1;
            vcsr_valid_o = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
